// File: rtl/branch_predictor.sv
// Direct-mapped branch history table + branch target buffer with combinational lookup.
// Optional perf counters are built only when BPRED_PERF_EN is defined.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_jalr,
    input  logic        upd_mispredict,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);
    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_reg  [ENTRIES];
    logic [TAG_W-1:0] tag_reg    [ENTRIES];
    logic [1:0]       ctr_reg    [ENTRIES];
    logic [31:0]      target_reg [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             wr_en;
    logic [1:0]       ctr_next;
    logic [31:0]      target_next;

    assign lk_idx  = if_pc[IDX_W+1:2];
    assign lk_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign lk_hit      = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_reg[lk_idx][1];
    assign pred_target = pred_taken ? target_reg[lk_idx] : (if_pc + 32'd4);

    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
    // Indirect jumps never train; not-taken misses never allocate.
    assign wr_en   = upd_valid && !upd_jalr && (upd_hit || upd_taken);

    always_comb begin
        ctr_next    = 2'b10;
        target_next = upd_target;
        if (upd_hit) begin
            if (upd_taken) begin
                ctr_next = (ctr_reg[upd_idx] == 2'b11) ? 2'b11 : ctr_reg[upd_idx] + 2'b01;
            end else begin
                ctr_next    = (ctr_reg[upd_idx] == 2'b00) ? 2'b00 : ctr_reg[upd_idx] - 2'b01;
                target_next = target_reg[upd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                ctr_reg[i]    <= 2'b01;
                target_reg[i] <= '0;
            end
        end else if (wr_en) begin
            valid_reg[upd_idx]  <= 1'b1;
            tag_reg[upd_idx]    <= upd_tag;
            ctr_reg[upd_idx]    <= ctr_next;
            target_reg[upd_idx] <= target_next;
        end
    end

`ifdef BPRED_PERF_EN
    logic [1:0] perf_inc;
    assign perf_inc = {upd_valid && upd_mispredict, upd_valid};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            // Saturate rather than wrap so long runs never under-report.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_branches    = g_perf[0].cnt_reg;
    assign perf_mispredicts = g_perf[1].cnt_reg;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0], upd_mispredict};
`endif

endmodule
